seq_det_ctrl: RTL

- Programmable serial pattern-detector controller for the sequence-detector family: accepts one configuration per run (pattern, overlap mode, match threshold), then scans a qualified serial bit stream.
- Emits a Mealy match pulse, keeps a saturating match count and raises a sticky threshold flag.
- Sits between the serial bit source and downstream interrupt or status logic; replaces hard-wired 1011 detectors.

---
 rtl/seq_det_ctrl_if.sv | 37 +++
 rtl/seq_det_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/seq_det_ctrl_if.sv
// ============================================================================
// Module      : seq_det_ctrl_if
// Description : Configuration, serial-stream and status bundle for
//               seq_det_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_det_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();
    logic             CFG_VALID;
    logic             CFG_READY;
    logic [PAT_W-1:0] CFG_PAT;
    logic             CFG_OVL;
    logic [CNT_W-1:0] CFG_THR;
    logic             IN;
    logic             IN_VALID;
    logic             CLR;
    logic             OUT;
    logic [CNT_W-1:0] MATCH_CNT;
    logic             THR_HIT;
    logic             BUSY;

    modport master (
        output CFG_VALID, CFG_PAT, CFG_OVL, CFG_THR, IN, IN_VALID, CLR,
        input  CFG_READY, OUT, MATCH_CNT, THR_HIT, BUSY
    );

    modport slave (
        input  CFG_VALID, CFG_PAT, CFG_OVL, CFG_THR, IN, IN_VALID, CLR,
        output CFG_READY, OUT, MATCH_CNT, THR_HIT, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/seq_det_ctrl.sv
// ============================================================================
// Module      : seq_det_ctrl
// Description : Programmable serial pattern detector with Mealy match pulse,
//               saturating match counter and sticky threshold flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    seq_det_ctrl_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic               r_ovl;
    logic [CNT_W-1:0]   r_thr;
    logic [PAT_W-2:0]   r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_hit;
    logic               r_cfg_ready;
    logic               r_busy;

    logic [PAT_W-1:0]   w_window;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [FILL_W-1:0]  w_fill_inc;

    // Window is the held history with the current bit appended as LSB.
    assign w_window   = {r_hist, bus.IN};
    assign w_match    = (r_state == ST_RUN) && bus.IN_VALID && !bus.CLR && RST &&
                        (r_fill == c_fill_max) && (w_window == r_pat);
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_fill_inc = (r_fill == c_fill_max) ? r_fill : r_fill + FILL_W'(1);

    assign bus.OUT       = w_match;
    assign bus.CFG_READY = r_cfg_ready;
    assign bus.BUSY      = r_busy;
    assign bus.MATCH_CNT = r_cnt;
    assign bus.THR_HIT   = r_hit;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_pat       <= '0;
            r_ovl       <= 1'b0;
            r_thr       <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_hit       <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.CLR) begin
                        r_cnt  <= '0;
                        r_hit  <= 1'b0;
                        r_hist <= '0;
                        r_fill <= '0;
                    end
                    // A handshake coinciding with CLR still launches the run.
                    if (bus.CFG_VALID && r_cfg_ready) begin
                        r_pat       <= bus.CFG_PAT;
                        r_ovl       <= bus.CFG_OVL;
                        r_thr       <= bus.CFG_THR;
                        r_state     <= ST_RUN;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.CLR) begin
                        r_cnt       <= '0;
                        r_hit       <= 1'b0;
                        r_hist      <= '0;
                        r_fill      <= '0;
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (bus.IN_VALID) begin
                        if (w_match && !r_ovl) begin
                            r_hist <= '0;
                            r_fill <= '0;
                        end else begin
                            r_hist <= w_window[PAT_W-2:0];
                            r_fill <= w_fill_inc;
                        end
                        if (w_match) begin
                            r_cnt <= w_cnt_inc;
                            // Compare against the post-increment value so a
                            // saturated counter with thr at max still sets.
                            if ((r_thr != '0) && (w_cnt_inc == r_thr)) begin
                                r_hit <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

`default_nettype wire
